// File: rtl/prod_accumulator_if.sv
// prod_accumulator_if: product stream in, frame sum out, both valid/ready
interface prod_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic [PROD_W-1:0] in_prod;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  modport master (output in_valid, in_prod, out_ready, input in_ready, out_valid, out_sum, out_ovf);
  modport slave  (input in_valid, in_prod, out_ready, output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums COUNT unsigned products into a saturating frame sum with valid/ready handoff
module prod_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int COUNT  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic busy,
  prod_accumulator_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic [CW-1:0]    cnt_n;
  assign sum   = {1'b0, acc} + (ACC_W+1)'(bus.in_prod);
  assign cnt_n = cnt + 1'b1;
  assign bus.in_ready  = state != HOLD;
  assign bus.out_valid = state == HOLD;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign busy          = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (state == HOLD) begin
      if (bus.out_ready) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end
    end else if (bus.in_valid) begin
      // the carry out of the widened sum pins acc at all ones for the rest of the frame
      acc   <= state == IDLE ? ACC_W'(bus.in_prod) : sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      ovf   <= state == IDLE ? 1'b0 : ovf | sum[ACC_W];
      cnt   <= cnt_n;
      state <= cnt_n == CW'(COUNT) ? HOLD : ACCUM;
    end
  end
endmodule
